// File: rtl/wb_retry_timeout.sv
// wb_retry_timeout: Wishbone classic-cycle guard that reissues retried cycles and times out hung ones.
// Ports: clk/rst (async active-high); m_* master side (adr/dat/we/sel/stb/cyc in, dat/ack/err/rty out);
// s_* slave side (adr/dat/we/sel/stb/cyc out, dat/ack/err/rty in). All outputs are registered.
module wb_retry_timeout #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 1024,
    parameter int RETRY_COUNT  = 3,
    parameter int RETRY_DELAY  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [DATA_WIDTH-1:0]   m_dat_i,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    input  logic                    m_we_i,
    input  logic [SELECT_WIDTH-1:0] m_sel_i,
    input  logic                    m_stb_i,
    output logic                    m_ack_o,
    output logic                    m_err_o,
    output logic                    m_rty_o,
    input  logic                    m_cyc_i,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic                    s_we_o,
    output logic [SELECT_WIDTH-1:0] s_sel_o,
    output logic                    s_stb_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    output logic                    s_cyc_o
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = (RETRY_COUNT > 0) ? $clog2(RETRY_COUNT + 1) : 1;
    localparam int DW = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY + 1) : 1;
    localparam logic [TW-1:0] TMAX  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [RW-1:0] RMAX  = RW'(RETRY_COUNT);
    localparam logic [DW-1:0] DLOAD = DW'((RETRY_DELAY > 0) ? RETRY_DELAY : 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, BACKOFF} state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;
    logic [DW-1:0] r_delay;
    logic          w_timeout;
    logic          w_clear;
    logic          w_accept;

    assign w_timeout = (TIMEOUT != 0) && (r_timer == TMAX);
    // Terminations that end the transaction with err/rty also wipe the latched request.
    assign w_clear   = (r_state == ACTIVE) && m_cyc_i && !s_ack_i &&
                       (s_err_i || (s_rty_i ? (r_retry == RMAX) : w_timeout));
    // A strobe still held during our own response cycle is the old request, not a new one.
    assign w_accept  = m_cyc_i && m_stb_i && !(m_ack_o || m_err_o || m_rty_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_retry <= '0;
            r_delay <= '0;
            m_dat_o <= '0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_rty_o <= 1'b0;
            s_adr_o <= '0;
            s_dat_o <= '0;
            s_we_o  <= 1'b0;
            s_sel_o <= '0;
            s_stb_o <= 1'b0;
            s_cyc_o <= 1'b0;
        end else begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_rty_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        s_adr_o <= m_adr_i;
                        s_dat_o <= m_dat_i;
                        s_we_o  <= m_we_i;
                        s_sel_o <= m_sel_i;
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        r_timer <= '0;
                        r_retry <= '0;
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (TIMEOUT != 0) r_timer <= r_timer + TW'(1);
                    if (!m_cyc_i || s_ack_i || s_err_i || s_rty_i || w_timeout) begin
                        s_cyc_o <= 1'b0;
                        s_stb_o <= 1'b0;
                        r_state <= IDLE;
                    end
                    if (!m_cyc_i) begin
                    end else if (s_ack_i) begin
                        m_ack_o <= 1'b1;
                        m_dat_o <= s_dat_i;
                    end else if (s_err_i) begin
                        m_err_o <= 1'b1;
                    end else if (s_rty_i && r_retry != RMAX) begin
                        r_retry <= r_retry + RW'(1);
                        r_delay <= DLOAD;
                        r_state <= BACKOFF;
                    end else if (s_rty_i) begin
                        m_rty_o <= 1'b1;
                    end else if (w_timeout) begin
                        m_err_o <= 1'b1;
                    end
                    if (w_clear) begin
                        s_adr_o <= '0;
                        s_dat_o <= '0;
                        s_we_o  <= 1'b0;
                        s_sel_o <= '0;
                    end
                end
                BACKOFF: begin
                    // Reissue on the edge where the delay count is 1, giving a gap of exactly RETRY_DELAY cycles.
                    r_delay <= r_delay - DW'(1);
                    if (!m_cyc_i) begin
                        r_state <= IDLE;
                    end else if (r_delay == DW'(1)) begin
                        s_cyc_o <= 1'b1;
                        s_stb_o <= 1'b1;
                        r_timer <= '0;
                        r_state <= ACTIVE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_retry_timeout.sv
// tb_wb_retry_timeout: table-driven scoreboard bench for wb_retry_timeout.
module tb_wb_retry_timeout;
    localparam int DW = 32, AW = 32, SW = 4, TO = 16, RC = 3, RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m_adr_i, s_adr_o;
    logic [DW-1:0] m_dat_i, m_dat_o, s_dat_i, s_dat_o;
    logic [SW-1:0] m_sel_i, s_sel_o;
    logic          m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o, m_rty_o;
    logic          s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i;

    wb_retry_timeout #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
        .TIMEOUT(TO), .RETRY_COUNT(RC), .RETRY_DELAY(RD)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_rty_o(m_rty_o), .m_cyc_i(m_cyc_i),
        .s_adr_o(s_adr_o), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_rty_i(s_rty_i), .s_cyc_o(s_cyc_o)
    );

    always #5 clk = ~clk;

    // kinds: 1 ack, 2 err, 3 rty; slave final: 0 ack, 1 err, 2 silent
    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            wt;
        int            nrty;
        int            fin;
        logic [DW-1:0] rdat;
        int            e_kind;
        int            e_rises;
        int            e_run;
        int            e_lat;
        logic [DW-1:0] e_dat;
    } vec_t;

    typedef struct {
        int            kind;
        logic [DW-1:0] dat;
    } exp_t;

    vec_t vt[8];
    exp_t sb[$];

    int tests = 0, fails = 0, n_exp = 0;

    int sl_wt = 0, sl_nrty = 0, sl_fin = 2, sl_att = 0, sl_cnt = 0;
    logic [DW-1:0] sl_rdat = '0;

    int mon_rises = 0, mon_run = 0, mon_gap = 0, mon_gap_bad = 0, mon_adr_bad = 0;
    int mon_resp = 0, mon_excl_bad = 0;
    logic mon_prev = 1'b0;
    logic [AW-1:0] cur_adr = '0;
    logic [DW-1:0] cur_dat = '0;
    logic [SW-1:0] cur_sel = '0;
    logic          cur_we = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Slave model: responds after wt extra wait cycles per attempt, retrying the first nrty attempts.
    initial begin
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
            s_dat_i = sl_rdat;
            if (s_stb_o && !rst) begin
                sl_cnt++;
                if (sl_cnt == sl_wt + 1) begin
                    if (sl_att < sl_nrty) s_rty_i = 1'b1;
                    else if (sl_fin == 0) s_ack_i = 1'b1;
                    else if (sl_fin == 1) s_err_i = 1'b1;
                    sl_att++;
                end
            end else begin
                sl_cnt = 0;
            end
        end
    end

    // Monitor: strobe episodes, gaps, held request fields, response exclusivity.
    initial forever begin
        @(negedge clk);
        if (s_stb_o) begin
            if (!mon_prev) begin
                mon_rises++;
                if (mon_rises > 1 && mon_gap != RD) mon_gap_bad++;
                mon_run = 0;
                mon_gap = 0;
            end
            mon_run++;
            if (s_adr_o !== cur_adr || s_sel_o !== cur_sel || s_we_o !== cur_we ||
                s_dat_o !== cur_dat || s_cyc_o !== 1'b1) mon_adr_bad++;
        end else begin
            mon_gap++;
        end
        mon_resp += int'(m_ack_o) + int'(m_err_o) + int'(m_rty_o);
        if (int'(m_ack_o) + int'(m_err_o) + int'(m_rty_o) > 1) mon_excl_bad++;
        mon_prev = s_stb_o;
    end

    task automatic wait_resp(input logic scramble, output int kind, output int lat);
        kind = 0;
        lat = 0;
        while (kind == 0 && lat < 200) begin
            @(negedge clk);
            lat++;
            kind = m_ack_o ? 1 : m_err_o ? 2 : m_rty_o ? 3 : 0;
            if (kind == 0 && lat == 1 && scramble) begin
                m_adr_i = ~m_adr_i;
                m_dat_i = $urandom;
                m_sel_i = ~m_sel_i;
                m_we_i  = ~m_we_i;
            end
        end
        if (kind == 0) chk("resp_timeout", 64'(kind), 64'd1);
    endtask

    task automatic sb_check(input string nm, input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, "_kind"}, 64'(kind), 64'(e.kind));
            chk({nm, "_mdat"}, 64'(m_dat_o), 64'(e.dat));
        end
    endtask

    task automatic setup(input vec_t v);
        sl_wt = v.wt; sl_nrty = v.nrty; sl_fin = v.fin; sl_rdat = v.rdat; sl_att = 0;
        cur_adr = v.adr; cur_dat = v.dat; cur_sel = v.sel; cur_we = v.we;
        mon_rises = 0; mon_gap = 0; mon_gap_bad = 0; mon_adr_bad = 0;
    endtask

    task automatic drive(input vec_t v);
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        m_we_i = v.we; m_adr_i = v.adr; m_dat_i = v.dat; m_sel_i = v.sel;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int kind, lat;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk); #1;
        setup(v);
        drive(v);
        sb.push_back('{v.e_kind, v.e_dat});
        n_exp++;
        wait_resp(1'b1, kind, lat);
        #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        sb_check(nm, kind);
        chk({nm, "_lat"}, 64'(lat), 64'(v.e_lat));
        chk({nm, "_rises"}, 64'(mon_rises), 64'(v.e_rises));
        chk({nm, "_run"}, 64'(mon_run), 64'(v.e_run));
        chk({nm, "_gap_bad"}, 64'(mon_gap_bad), 64'd0);
        chk({nm, "_req_bad"}, 64'(mon_adr_bad), 64'd0);
        @(negedge clk);
        chk({nm, "_pulse"}, {61'd0, m_ack_o, m_err_o, m_rty_o}, 64'd0);
        chk({nm, "_cyc_low"}, 64'(s_cyc_o), 64'd0);
    endtask

    initial begin
        int kind, lat, resp0;
        vec_t v;
        vt[0] = '{1'b1, 32'h100, 32'h11223344, 4'hF,   0, 0, 0, 32'h0,        1, 1,  1,  2, 32'h0};
        vt[1] = '{1'b0, 32'h200, 32'h0,        4'hF,   5, 0, 0, 32'hDEADBEEF, 1, 1,  6,  7, 32'hDEADBEEF};
        vt[2] = '{1'b0, 32'h300, 32'h0,        4'h3,   0, 2, 0, 32'hCAFEF00D, 1, 3,  1, 12, 32'hCAFEF00D};
        vt[3] = '{1'b1, 32'h400, 32'h55667788, 4'hC,   0, 4, 0, 32'h99999999, 3, 4,  1, 17, 32'hCAFEF00D};
        vt[4] = '{1'b0, 32'h500, 32'h0,        4'hF, 100, 0, 2, 32'h0,        2, 1, 16, 17, 32'hCAFEF00D};
        vt[5] = '{1'b0, 32'h600, 32'h0,        4'hF,  15, 0, 0, 32'h0BADC0DE, 1, 1, 16, 17, 32'h0BADC0DE};
        vt[6] = '{1'b1, 32'h700, 32'hA0B0C0D0, 4'h1,   2, 0, 1, 32'h0,        2, 1,  3,  4, 32'h0BADC0DE};
        vt[7] = '{1'b0, 32'h800, 32'h0,        4'hF,   1, 1, 0, 32'h12345678, 1, 2,  2,  9, 32'h12345678};

        rst = 1'b1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_resp", {61'd0, m_ack_o, m_err_o, m_rty_o}, 64'd0);
        chk("rst_s_cyc_stb", {62'd0, s_cyc_o, s_stb_o}, 64'd0);
        chk("rst_m_dat", 64'(m_dat_o), 64'd0);
        chk("rst_s_adr", 64'(s_adr_o), 64'd0);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // Back-to-back reads with the strobe held through the ack cycle.
        @(negedge clk); #1;
        v = vt[1];
        v.wt = 0; v.rdat = 32'hA5A50001;
        setup(v);
        drive(v);
        sb.push_back('{1, 32'hA5A50001});
        sb.push_back('{1, 32'hA5A50002});
        n_exp += 2;
        wait_resp(1'b0, kind, lat);
        sb_check("b2b_first", kind);
        #1;
        m_adr_i = 32'h204; cur_adr = 32'h204; sl_rdat = 32'hA5A50002; sl_att = 0;
        @(negedge clk);
        chk("b2b_guard_stb", 64'(s_stb_o), 64'd0);
        @(negedge clk);
        chk("b2b_second_stb", 64'(s_stb_o), 64'd1);
        chk("b2b_second_adr", 64'(s_adr_o), 64'h204);
        wait_resp(1'b0, kind, lat);
        #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        sb_check("b2b_second", kind);
        chk("b2b_req_bad", 64'(mon_adr_bad), 64'd0);

        // Master abort during backoff.
        repeat (2) @(negedge clk);
        #1;
        v = vt[3];
        v.adr = 32'h900;
        setup(v);
        drive(v);
        resp0 = mon_resp;
        repeat (2) @(negedge clk);
        chk("abort_in_backoff_stb", 64'(s_stb_o), 64'd0);
        #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_rises", 64'(mon_rises), 64'd1);
        chk("abort_no_resp", 64'(mon_resp - resp0), 64'd0);
        chk("abort_cyc_low", 64'(s_cyc_o), 64'd0);

        // Asynchronous reset while ACTIVE.
        v = vt[4];
        v.adr = 32'hA00;
        setup(v);
        drive(v);
        resp0 = mon_resp;
        repeat (3) @(negedge clk);
        chk("rstmid_active_stb", 64'(s_stb_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_async_drop", {62'd0, s_cyc_o, s_stb_o}, 64'd0);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rstmid_no_resp", 64'(mon_resp - resp0), 64'd0);

        run_vec(8, vt[1]);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("resp_total", 64'(mon_resp), 64'(n_exp));
        chk("resp_exclusive", 64'(mon_excl_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_retry_timeout.md
Name: wb_retry_timeout

Overview:
Wishbone classic-cycle guard stage. It sits directly downstream of the wishbone register slice and upstream of a slave or interconnect segment. It reissues cycles the slave terminates with retry, up to a bounded count with a fixed backoff. It terminates hung cycles with an error after a cycle-count timeout, so a stuck slave cannot lock the master.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address bus width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT, 1024, max cycles s_stb_o stays high per attempt; 0 disables timeout
RETRY_COUNT, 3, max reissues after s_rty_i before rty is passed to master
RETRY_DELAY, 4, idle cycles between a retry termination and the reissue (min 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m_adr_i  in  ADDR_WIDTH  master address
m_dat_i  in  DATA_WIDTH  master write data
m_dat_o  out  DATA_WIDTH  read data to master
m_we_i  in  1  write enable
m_sel_i  in  SELECT_WIDTH  byte selects
m_stb_i  in  1  strobe
m_ack_o  out  1  ack to master
m_err_o  out  1  error to master (slave err or timeout)
m_rty_o  out  1  retry to master (retries exhausted)
m_cyc_i  in  1  cycle
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_i  in  DATA_WIDTH  slave read data
s_dat_o  out  DATA_WIDTH  slave write data
s_we_o  out  1  slave write enable
s_sel_o  out  SELECT_WIDTH  slave byte selects
s_stb_o  out  1  slave strobe
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
s_rty_i  in  1  slave retry
s_cyc_o  out  1  slave cycle

Behaviour:
- Single clock clk. rst is asynchronous, active-high.
- On reset all outputs are 0, state is IDLE, and timer and retry counters are 0.
- All outputs are registered.
- m_ack_o, m_err_o and m_rty_o are single-cycle pulses and are mutually exclusive.
- IDLE:
  - Accept when m_cyc_i & m_stb_i & ~(m_ack_o|m_err_o|m_rty_o). The guard blocks the stale strobe held during a response cycle.
  - On accept, latch adr/dat/we/sel into the s_* outputs and set s_cyc_o=s_stb_o=1. Clear the timer and retry count, then go to ACTIVE.
- ACTIVE: timer increments each cycle. Evaluate at each edge in this priority order:
  - m_cyc_i=0 (master abort): clear s_cyc_o/s_stb_o, no master response, go to IDLE. Abort beats a simultaneous slave response.
  - s_ack_i: clear s_cyc_o/s_stb_o, pulse m_ack_o, set m_dat_o<=s_dat_i, go to IDLE.
  - s_err_i: clear s_*, pulse m_err_o, go to IDLE.
  - s_rty_i with retry count < RETRY_COUNT: clear s_cyc_o/s_stb_o, increment retry count, load delay with RETRY_DELAY, go to BACKOFF.
  - s_rty_i with retry count = RETRY_COUNT: clear s_*, pulse m_rty_o, go to IDLE.
  - TIMEOUT != 0 and timer = TIMEOUT-1 with no response: clear s_*, pulse m_err_o, go to IDLE. A slave response in that same cycle wins over the timeout.
- BACKOFF:
  - s_cyc_o=s_stb_o=0; latched adr/dat/we/sel are held unchanged.
  - Delay decrements each cycle.
  - m_cyc_i=0: go to IDLE, no response.
  - On the last delay cycle: reassert s_cyc_o/s_stb_o, clear the timer, go to ACTIVE. The gap is exactly RETRY_DELAY cycles.
- Latency:
  - s_stb_o rises 1 cycle after the master strobe is sampled.
  - The master response rises 1 cycle after the slave response.
  - Zero-wait slave: m_ack_o appears 2 cycles after m_stb_i.
- m_dat_o holds its last value outside ack cycles. It updates only on ack.
- Counter widths: timer is clog2(TIMEOUT+1) bits; retry count is clog2(RETRY_COUNT+1) bits. Neither counter wraps, since each is reset per attempt or transaction.
- Master inputs changing while not in IDLE are ignored. Only m_cyc_i is monitored.
- Reset mid-transaction: s_cyc_o/s_stb_o drop asynchronously and no response is issued.

Test Plan:
1. Write adr 0x100, dat 0x11223344, sel 0xF; slave acks on its first strobe cycle -> s_adr_o=0x100, s_dat_o=0x11223344, s_stb_o high 1 cycle, m_ack_o one pulse 2 cycles after m_stb_i, no err/rty.
2. Read adr 0x200; slave acks after 5 wait cycles with 0xDEADBEEF -> s_stb_o high 6 cycles, m_ack_o pulse with m_dat_o=0xDEADBEEF; back-to-back second read accepted only after the ack cycle.
3. RETRY_COUNT=3, RETRY_DELAY=4; slave rty twice then ack -> 3 s_stb_o assertions separated by exactly 4 low cycles, same adr/sel each time, one m_ack_o, m_rty_o never set.
4. Slave asserts rty on every attempt -> 4 s_stb_o assertions (1+3), then one m_rty_o pulse, s_cyc_o low.
5. TIMEOUT=16, slave silent -> s_stb_o high exactly 16 cycles then low, one m_err_o pulse. Repeat with s_ack_i on the 16th cycle -> m_ack_o, no m_err_o.
6. Master drops m_cyc_i during BACKOFF, and separately rst asserted mid-ACTIVE -> s_cyc_o low (next edge / immediately), no m_ack_o/m_err_o/m_rty_o, next request accepted normally.
